// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared types, constants and cell helpers for the maze solver
package maze_pkg;

    localparam int MAZE_DIM    = 16;
    localparam int MAZE_CELLS  = 256;
    localparam int CELL_W      = 8;
    localparam int STACK_DEPTH = 256;

    localparam logic CELL_OPEN = 1'b1;
    localparam logic CELL_WALL = 1'b0;

    typedef logic [CELL_W-1:0] cell_idx_t;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } state_e;

    typedef struct packed {
        logic      valid;
        cell_idx_t idx;
    } nbr_t;

    function automatic cell_idx_t cell_idx(input logic [3:0] x, input logic [3:0] y);
        return {y, x};
    endfunction

    // Bounds are tested on the coordinates before forming the index, so no edge wraps.
    function automatic nbr_t step_cell(input cell_idx_t c, input dir_e d);
        nbr_t       n;
        logic [3:0] x;
        logic [3:0] y;
        x = c[3:0];
        y = c[7:4];
        n.valid = 1'b0;
        n.idx   = c;
        case (d)
            DIR_RIGHT: if (x != 4'd15) begin n.valid = 1'b1; n.idx = cell_idx(x + 4'd1, y); end
            DIR_DOWN:  if (y != 4'd15) begin n.valid = 1'b1; n.idx = cell_idx(x, y + 4'd1); end
            DIR_LEFT:  if (x != 4'd0)  begin n.valid = 1'b1; n.idx = cell_idx(x - 4'd1, y); end
            default:   if (y != 4'd0)  begin n.valid = 1'b1; n.idx = cell_idx(x, y - 4'd1); end
        endcase
        return n;
    endfunction

endpackage

// File: rtl/maze_solver_if.sv
// rtl/maze_solver_if.sv - request/result bundle between the maze solver and its user
interface maze_solver_if;
    logic         start;
    logic [255:0] maze_data;
    logic [3:0]   start_x;
    logic [3:0]   start_y;
    logic [3:0]   goal_x;
    logic [3:0]   goal_y;
    logic         busy;
    logic         done;
    logic         found;
    logic [255:0] path_map;
    logic [3:0]   curr_x;
    logic [3:0]   curr_y;
    logic [8:0]   step_count;

    modport master (
        output start, maze_data, start_x, start_y, goal_x, goal_y,
        input  busy, done, found, path_map, curr_x, curr_y, step_count
    );

    modport slave (
        input  start, maze_data, start_x, start_y, goal_x, goal_y,
        output busy, done, found, path_map, curr_x, curr_y, step_count
    );
endinterface

// File: rtl/maze_stack.sv
// rtl/maze_stack.sv - LIFO of visited cell indexes with a combinational top
module maze_stack
    import maze_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clr_i,
    input  logic      push_i,
    input  logic      pop_i,
    input  cell_idx_t data_i,
    output cell_idx_t top_o,
    output logic      empty_o
);

    cell_idx_t  mem_q [STACK_DEPTH];
    logic [8:0] sp_q;
    cell_idx_t  top_addr;

    assign top_addr = sp_q[7:0] - 8'd1;
    assign top_o    = mem_q[top_addr];
    assign empty_o  = (sp_q == 9'd0);

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[sp_q[7:0]] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= 9'd0;
        end else if (clr_i) begin
            sp_q <= 9'd0;
        end else if (push_i) begin
            sp_q <= sp_q + 9'd1;
        end else if (pop_i) begin
            sp_q <= sp_q - 9'd1;
        end
    end

endmodule

// File: rtl/maze_solver.sv
// rtl/maze_solver.sv - depth-first maze solver, one move or backtrack per clock
module maze_solver
    import maze_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    maze_solver_if.slave bus
);

    state_e          state_q;
    cell_idx_t       curr_q;
    cell_idx_t       goal_q;
    logic [255:0]    visited_q;
    logic [255:0]    path_q;
    logic            busy_q;
    logic            done_q;
    logic            found_q;
    logic [8:0]      step_q;
    logic [8:0]      step_d;

    cell_idx_t       start_idx;
    logic            at_goal;
    logic            cand_ok;
    cell_idx_t       cand_idx;
    nbr_t            nb;
    logic            stk_clr;
    logic            stk_push;
    logic            stk_pop;
    cell_idx_t       stk_top;
    logic            stk_empty;

    assign start_idx = cell_idx(bus.start_x, bus.start_y);
    assign at_goal   = (curr_q == goal_q);
    assign step_d    = (step_q == 9'd511) ? step_q : step_q + 9'd1;

    // Walk directions lowest priority first so the highest-priority candidate wins.
    always_comb begin
        cand_ok  = 1'b0;
        cand_idx = curr_q;
        nb       = '0;
        for (int d = 3; d >= 0; d--) begin
            nb = step_cell(curr_q, dir_e'(d[1:0]));
            if (nb.valid && bus.maze_data[nb.idx] == CELL_OPEN && !visited_q[nb.idx]) begin
                cand_ok  = 1'b1;
                cand_idx = nb.idx;
            end
        end
    end

    assign stk_clr  = (state_q == ST_IDLE) && bus.start;
    assign stk_push = (state_q == ST_SEARCH) && !at_goal && cand_ok;
    assign stk_pop  = (state_q == ST_SEARCH) && !at_goal && !cand_ok && !stk_empty;

    maze_stack u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (stk_clr),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .data_i  (curr_q),
        .top_o   (stk_top),
        .empty_o (stk_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            curr_q    <= '0;
            goal_q    <= '0;
            visited_q <= '0;
            path_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            step_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        goal_q  <= cell_idx(bus.goal_x, bus.goal_y);
                        curr_q  <= start_idx;
                        found_q <= 1'b0;
                        step_q  <= '0;
                        if (bus.maze_data[start_idx] == CELL_OPEN) begin
                            visited_q <= 256'd1 << start_idx;
                            path_q    <= 256'd1 << start_idx;
                            busy_q    <= 1'b1;
                            state_q   <= ST_SEARCH;
                        end else begin
                            visited_q <= '0;
                            path_q    <= '0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (at_goal) begin
                        done_q  <= 1'b1;
                        found_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cand_ok) begin
                        curr_q              <= cand_idx;
                        visited_q[cand_idx] <= 1'b1;
                        path_q[cand_idx]    <= 1'b1;
                        step_q              <= step_d;
                    end else if (stk_empty) begin
                        done_q  <= 1'b1;
                        found_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        path_q[curr_q] <= 1'b0;
                        curr_q         <= stk_top;
                        step_q         <= step_d;
                    end
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.found      = found_q;
    assign bus.path_map   = path_q;
    assign bus.curr_x     = curr_q[3:0];
    assign bus.curr_y     = curr_q[7:4];
    assign bus.step_count = step_q;

endmodule

// File: tb/tb_maze_solver.sv
// tb/tb_maze_solver.sv - directed self-checking bench for maze_solver
module tb_maze_solver;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    maze_solver_if bus();

    maze_solver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses start at E0, counts edges until done; inject_at >= 0 pulses start mid-search.
    task automatic run(input string tag, input logic [3:0] sx, input logic [3:0] sy,
                       input logic [3:0] gx, input logic [3:0] gy, input int exp_edges,
                       input logic exp_found, input int exp_step, input logic [255:0] exp_path,
                       input int inject_at);
        int n;
        bus.start_x = sx;
        bus.start_y = sy;
        bus.goal_x  = gx;
        bus.goal_y  = gy;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk({tag, "_busy0"}, bus.busy, exp_edges > 0);
        n = 0;
        while (!bus.done && n < 600) begin
            if (n == inject_at) begin
                bus.start   = 1'b1;
                bus.start_x = 4'd9;
                bus.start_y = 4'd9;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.start = 1'b0;
        chk({tag, "_edges"}, n, exp_edges);
        chk({tag, "_found"}, bus.found, exp_found);
        chk({tag, "_steps"}, bus.step_count, exp_step);
        chk({tag, "_path"}, bus.path_map, exp_path);
        @(posedge clk);
        #1;
        chk({tag, "_done_drop"}, bus.done, 1'b0);
        chk({tag, "_found_hold"}, bus.found, exp_found);
    endtask

    logic [255:0] m;
    logic [255:0] p;
    int           done_seen;

    initial begin
        checks        = 0;
        errors        = 0;
        bus.start     = 1'b0;
        bus.maze_data = '0;
        bus.start_x   = '0;
        bus.start_y   = '0;
        bus.goal_x    = '0;
        bus.goal_y    = '0;
        rst_n         = 1'b0;
        #1;
        chk("rst_outputs", {bus.busy, bus.done, bus.found, bus.curr_x, bus.curr_y, bus.step_count}, '0);
        chk("rst_path", bus.path_map, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        m = '0;
        m[3:0] = 4'hF;
        bus.maze_data = m;
        run("corridor", 4'd0, 4'd0, 4'd3, 4'd0, 4, 1'b1, 3, 256'hF, -1);

        m = '1;
        bus.maze_data = m;
        p = '0;
        p[85] = 1'b1;
        run("goal_eq_start", 4'd5, 4'd5, 4'd5, 4'd5, 1, 1'b1, 0, p, -1);

        m = '0;
        bus.maze_data = m;
        run("start_wall", 4'd2, 4'd3, 4'd4, 4'd4, 0, 1'b0, 0, '0, -1);

        m = '0;
        m[0] = 1'b1; m[1] = 1'b1; m[2] = 1'b1; m[16] = 1'b1; m[32] = 1'b1;
        bus.maze_data = m;
        p = '0;
        p[0] = 1'b1; p[16] = 1'b1; p[32] = 1'b1;
        run("dead_end", 4'd0, 4'd0, 4'd0, 4'd2, 7, 1'b1, 6, p, -1);

        m = '0;
        m[15] = 1'b1; m[16] = 1'b1;
        bus.maze_data = m;
        p = '0;
        p[15] = 1'b1;
        run("no_wrap", 4'd15, 4'd0, 4'd0, 4'd1, 1, 1'b0, 0, p, -1);

        // Open field, goal (0,15): right along row 0, down column 15, left along row 15.
        m = '1;
        bus.maze_data = m;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            p[i]           = 1'b1;
            p[15 + 16 * i] = 1'b1;
            p[240 + i]     = 1'b1;
        end
        run("ignored_start", 4'd0, 4'd0, 4'd0, 4'd15, 46, 1'b1, 45, p, 10);

        bus.start_x = 4'd0;
        bus.start_y = 4'd0;
        bus.goal_x  = 4'd0;
        bus.goal_y  = 4'd15;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_busy_pre", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {bus.busy, bus.done, bus.found, bus.curr_x, bus.curr_y, bus.step_count}, '0);
        chk("abort_path", bus.path_map, '0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);

        p = '0;
        for (int i = 0; i < 16; i++) begin
            p[i]           = 1'b1;
            p[15 + 16 * i] = 1'b1;
        end
        run("fresh_after_abort", 4'd0, 4'd0, 4'd15, 4'd15, 31, 1'b1, 30, p, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
